// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the iterative multiply/divide unit
// Contents: funct3 opcodes, the M-extension funct7 value and FSM state encoding.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - one combinational shift-add / restoring-subtract step
// Ports:
//   is_div   in   select divide step (1) or multiply step (0)
//   hi, lo   in   working register pair (mul: product hi/lo, div: remainder/quotient)
//   opb      in   multiplicand magnitude (mul) or divisor magnitude (div)
//   hi_next  out  next value of hi
//   lo_next  out  next value of lo
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier LSB is set,
        // then shift the whole {carry, hi, lo} right by one.
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        // Divide: bring the next dividend bit into the partial remainder.
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, opb};
        hi_next = '0;
        lo_next = '0;
        if (is_div) begin
            // MSB of diff set means the trial subtraction went negative: restore.
            if (!diff[XLEN]) begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply/divide execution unit
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     request handshake; in_ready is high only when idle
//   in_funct3, in_funct7  operation select; funct7 other than 0000001 is illegal
//   in_a, in_b            rs1 / rs2 operands
//   kill                  pipeline flush, aborts in-flight op or blocks accept
//   out_valid/out_ready   result handshake
//   out_result            rd value
//   out_illegal           request had a bad funct7 (result is 0)
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  opb;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;

    logic [XLEN-1:0] hi_next;
    logic [XLEN-1:0] lo_next;

    // Accept-side decode
    logic            illegal;
    logic            div0;
    logic            ovf;
    logic            signed_a;
    logic            signed_b;
    logic            a_neg_in;
    logic            b_neg_in;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special_res;

    // Completion-side sign fix
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   final_res;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_comb begin
        illegal  = (in_funct7 != FUNCT7_MULDIV);
        div0     = in_funct3[2] && (in_b == '0);
        // Only the signed divide ops (DIV, REM) can overflow.
        ovf      = in_funct3[2] && !in_funct3[0] && (in_a == MIN_INT) && (in_b == '1);
        signed_a = !(in_funct3 == F3_MULHU || in_funct3 == F3_DIVU || in_funct3 == F3_REMU);
        signed_b = signed_a && (in_funct3 != F3_MULHSU);
        a_neg_in = signed_a && in_a[XLEN-1];
        b_neg_in = signed_b && in_b[XLEN-1];
        // MIN_INT negates to itself, which is the correct unsigned magnitude.
        a_mag    = a_neg_in ? -in_a : in_a;
        b_mag    = b_neg_in ? -in_b : in_b;

        special_res = '0;
        if (illegal) begin
            special_res = '0;
        end else if (div0) begin
            special_res = in_funct3[1] ? in_a : '1;
        end else if (ovf) begin
            special_res = in_funct3[1] ? '0 : MIN_INT;
        end
    end

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .is_div  (f3_q[2]),
        .hi      (hi),
        .lo      (lo),
        .opb     (opb),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Sign fix is applied to the output of the final step so the result
    // registers in the same cycle the last iteration completes.
    always_comb begin
        prod_s = (a_neg ^ b_neg) ? -{hi_next, lo_next} : {hi_next, lo_next};
        quot_s = (a_neg ^ b_neg) ? -lo_next : lo_next;
        rem_s  = a_neg ? -hi_next : hi_next;
        final_res = '0;
        case (f3_q)
            F3_MUL:                       final_res = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              final_res = quot_s;
            F3_REM, F3_REMU:              final_res = rem_s;
            default:                      final_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            f3_q        <= '0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            opb         <= '0;
            hi          <= '0;
            lo          <= '0;
            out_result  <= '0;
            out_illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && !kill) begin
                        f3_q  <= in_funct3;
                        a_neg <= a_neg_in;
                        b_neg <= b_neg_in;
                        hi    <= '0;
                        // mul: lo holds the multiplier, opb the multiplicand
                        // div: lo holds the dividend,   opb the divisor
                        opb   <= in_funct3[2] ? b_mag : a_mag;
                        lo    <= in_funct3[2] ? a_mag : b_mag;
                        if (illegal || div0 || ovf) begin
                            out_result  <= special_res;
                            out_illegal <= illegal;
                            state       <= ST_DONE;
                        end else begin
                            cnt   <= CNT_W'(XLEN);
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (kill) begin
                        state <= ST_IDLE;
                    end else begin
                        hi  <= hi_next;
                        lo  <= lo_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            out_result  <= final_res;
                            out_illegal <= 1'b0;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (kill || out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = 3'd0;
    logic [6:0]  in_funct7 = 7'd1;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_illegal;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ill;
        logic [7:0]  lat;
    } exp_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t dir_q[$];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_a        (in_a),
        .in_b        (in_b),
        .kill        (kill),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_illegal (out_illegal)
    );

    function automatic exp_t model(input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa;
        longint      sbv;
        longint      ub;
        int          ia;
        int          ib;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ub  = longint'({32'd0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        e.res = 32'd0;
        e.ill = 1'b0;
        e.lat = 8'd33;
        p = 64'd0;
        if (f7 !== 7'b0000001) begin
            e.ill = 1'b1;
            e.lat = 8'd1;
            return e;
        end
        case (f3)
            F3_MUL:    begin p = sa * sbv; e.res = p[31:0]; end
            F3_MULH:   begin p = sa * sbv; e.res = p[63:32]; end
            F3_MULHSU: begin p = sa * ub;  e.res = p[63:32]; end
            F3_MULHU:  begin p = {32'd0, a} * {32'd0, b}; e.res = p[63:32]; end
            F3_DIV, F3_REM: begin
                if (b == 32'd0) begin
                    e.lat = 8'd1;
                    e.res = f3[1] ? a : 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lat = 8'd1;
                    e.res = f3[1] ? 32'd0 : a;
                end else begin
                    e.res = f3[1] ? 32'(ia % ib) : 32'(ia / ib);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.lat = 8'd1;
                    e.res = f3[1] ? a : 32'hFFFF_FFFF;
                end else begin
                    e.res = f3[1] ? (a % b) : (a / b);
                end
            end
        endcase
        return e;
    endfunction

    task automatic add(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic ill,
                       input logic [7:0] lat);
        vec_t v;
        v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
        v.e.res = res; v.e.ill = ill; v.e.lat = lat;
        dir_q.push_back(v);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
        sb.push_back(e);
        in_funct3 = f3;
        in_funct7 = f7;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic wait_out(output int lat, output int busy_bad);
        lat = 1;
        busy_bad = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0 || out_illegal !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h ill=%b want 1 0 0 0",
                     in_ready, out_valid, out_result, out_illegal);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        int   lat;
        int   bb;
        exp_t e;
        add(F3_MUL,    7'h01, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 8'd33);
        add(F3_MULH,   7'h01, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 8'd33);
        add(F3_MULHU,  7'h01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 8'd33);
        add(F3_MULHSU, 7'h01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 8'd33);
        add(F3_MULH,   7'h01, 32'hFFFF_FFFD,  32'd7,         32'hFFFF_FFFF, 1'b0, 8'd33);
        add(F3_MULHU,  7'h01, 32'h8000_0000,  32'd2,         32'd1,         1'b0, 8'd33);
        add(F3_DIV,    7'h01, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 8'd33);
        add(F3_REM,    7'h01, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 8'd33);
        add(F3_DIVU,   7'h01, 32'd100,        32'd7,         32'd14,        1'b0, 8'd33);
        add(F3_REMU,   7'h01, 32'd100,        32'd7,         32'd2,         1'b0, 8'd33);
        add(F3_DIV,    7'h01, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0, 8'd1);
        add(F3_REMU,   7'h01, 32'd5,          32'd0,         32'd5,         1'b0, 8'd1);
        add(F3_DIVU,   7'h01, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0, 8'd1);
        add(F3_REM,    7'h01, 32'd5,          32'd0,         32'd5,         1'b0, 8'd1);
        add(F3_DIV,    7'h01, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 8'd1);
        add(F3_REM,    7'h01, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 8'd1);
        add(F3_MUL,    7'h20, 32'd3,          32'd4,         32'd0,         1'b1, 8'd1);
        foreach (dir_q[i]) begin
            issue(dir_q[i].f3, dir_q[i].f7, dir_q[i].a, dir_q[i].b, dir_q[i].e);
            wait_out(lat, bb);
            e = sb.pop_front();
            tests++;
            if (out_valid !== 1'b1 || out_result !== e.res) begin
                failed++;
                $display("FAIL dir%0d_result: got vld=%b res=%h want vld=1 res=%h", i, out_valid, out_result, e.res);
            end
            tests++;
            if (out_illegal !== e.ill) begin
                failed++;
                $display("FAIL dir%0d_illegal: got %b want %b", i, out_illegal, e.ill);
            end
            tests++;
            if (lat !== int'(e.lat)) begin
                failed++;
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, e.lat);
            end
            tests++;
            if (bb != 0) begin
                failed++;
                $display("FAIL dir%0d_busy: in_ready high %0d cycles while busy, want 0", i, bb);
            end
            pop();
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failed++;
                $display("FAIL dir%0d_pop: got vld=%b rdy=%b want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        int   bb;
        int   bad;
        exp_t e;
        e.res = 32'd42; e.ill = 1'b0; e.lat = 8'd33;
        issue(F3_MUL, 7'h01, 32'd6, 32'd7, e);
        wait_out(lat, bb);
        e = sb.pop_front();
        // Offer a new request while the result waits; it must not be taken.
        in_funct3 = F3_MUL; in_funct7 = 7'h01; in_a = 32'd9; in_b = 32'd9;
        in_valid  = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid !== 1'b1 || out_result !== e.res || in_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL bp_hold: %0d unstable cycles, last vld=%b res=%h rdy=%b want 1 %h 0",
                     bad, out_valid, out_result, in_ready, e.res);
        end
        pop();
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL bp_no_accept_on_pop: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_kill();
        int   seen;
        exp_t e;
        e = model(F3_DIVU, 7'h01, 32'hFFFF_FFFF, 32'd3);
        issue(F3_DIVU, 7'h01, 32'hFFFF_FFFF, 32'd3, e);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        void'(sb.pop_front());
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL kill_calc: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            failed++;
            $display("FAIL kill_no_valid: out_valid high %0d cycles want 0", seen);
        end
        // kill while idle blocks the accept
        in_funct3 = F3_MUL; in_funct7 = 7'h01; in_a = 32'd2; in_b = 32'd3;
        in_valid = 1'b1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL kill_idle: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        // kill while a result waits drops it without a pop
        e = model(F3_DIV, 7'h01, 32'd5, 32'd0);
        issue(F3_DIV, 7'h01, 32'd5, 32'd0, e);
        void'(sb.pop_front());
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL kill_done: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_rst_mid();
        int   lat;
        int   bb;
        exp_t e;
        e = model(F3_MUL, 7'h01, 32'd6, 32'd7);
        issue(F3_MUL, 7'h01, 32'd6, 32'd7, e);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        void'(sb.pop_front());
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0 || out_illegal !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid: got rdy=%b vld=%b res=%h ill=%b want 1 0 0 0",
                     in_ready, out_valid, out_result, out_illegal);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        e.res = 32'd1; e.ill = 1'b0; e.lat = 8'd33;
        issue(F3_MULHU, 7'h01, 32'h8000_0000, 32'd2, e);
        wait_out(lat, bb);
        e = sb.pop_front();
        tests++;
        if (out_result !== e.res || lat !== int'(e.lat)) begin
            failed++;
            $display("FAIL rst_next_op: got res=%h lat=%0d want %h %0d", out_result, lat, e.res, e.lat);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          bb;
        exp_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom_range(0, 7));
            f7 = ($urandom_range(0, 9) == 0) ? 7'h20 : 7'h01;
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            issue(f3, f7, a, b, model(f3, f7, a, b));
            wait_out(lat, bb);
            e = sb.pop_front();
            tests++;
            if (out_result !== e.res || out_illegal !== e.ill || lat !== int'(e.lat)) begin
                failed++;
                $display("FAIL b2b%0d f3=%0d a=%h b=%h: got res=%h ill=%b lat=%0d want %h %b %0d",
                         i, f3, a, b, out_result, out_illegal, lat, e.res, e.ill, e.lat);
            end
            pop();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_kill();
        test_rst_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
